// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with a valid/ready handshake on each side.
// Logic ops finish in one cycle; shifts step one bit per clock.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            is_sll, is_sub, is_add;
  logic            is_xor, is_srl, is_or, is_and;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] acc_sh;

  assign is_sll = (alu_ctrl == 4'b0001);
  assign is_sub = (alu_ctrl == 4'b0010);
  assign is_add = (alu_ctrl == 4'b0011);
  assign is_xor = (alu_ctrl == 4'b0110);
  assign is_srl = (alu_ctrl == 4'b0111);
  assign is_or  = (alu_ctrl == 4'b1001);
  assign is_and = (alu_ctrl == 4'b1010);

  assign shamt  = op_b[SHW-1:0];
  assign acc_sh = left_q ? (acc_q << 1)
                         : (acc_q >> 1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_DONE;
          illegal_d = 1'b0;
          unique case (1'b1)
            is_add: result_d = op_a + op_b;
            is_sub: result_d = op_a - op_b;
            is_xor: result_d = op_a ^ op_b;
            is_or:  result_d = op_a | op_b;
            is_and: result_d = op_a & op_b;
            is_sll, is_srl: begin
              if (shamt == '0) begin
                result_d = op_a;
              end else begin
                state_d = S_SHIFT;
                acc_d   = op_a;
                cnt_d   = shamt;
                left_d  = is_sll;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d  = S_DONE;
          result_d = acc_sh;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // zero is captured together with the result it describes
    if (state_d == S_DONE && state_q != S_DONE)
      zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus random ops
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  function automatic logic [32:0] ref_op(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = int'(b % 32);
    case (c)
      4'd3:    return {1'b0, a + b};
      4'd2:    return {1'b0, a - b};
      4'd6:    return {1'b0, a ^ b};
      4'd9:    return {1'b0, a | b};
      4'd10:   return {1'b0, a & b};
      4'd1:    return {1'b0, a << n};
      4'd7:    return {1'b0, a >> n};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'd1 || c == 4'd7) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  // Issue one request at a negedge with in_ready high; returns at the
  // first negedge where out_valid is seen (or after a cycle budget).
  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r,
                        output logic z, output logic il);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = result; z = zero; il = illegal;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = 4'd0; op_a = '0; op_b = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 ||
        zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b res=%h z=%b il=%b want 0 1 0 0 0",
               out_valid, in_ready, result, zero, illegal);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed(input string nm, input logic [3:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    int lat; logic [31:0] r; logic z, il; logic [32:0] e; int el;
    e = ref_op(c, a, b); el = ref_lat(c, b);
    out_ready = 1'b1;
    run_op(c, a, b, lat, r, z, il);
    checks++;
    if (lat !== el || r !== e[31:0] || z !== (e[31:0] == 0) || il !== e[32]) begin
      errors++;
      $display("FAIL %s: lat=%0d res=%h z=%b il=%b want lat=%0d res=%h z=%b il=%b",
               nm, lat, r, z, il, el, e[31:0], e[31:0] == 0, e[32]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: ov=%b ir=%b want 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_shift_busy();
    int busy = 0;
    out_ready = 1'b1;
    alu_ctrl = 4'd1; op_a = 32'h1; op_b = 32'h24; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && busy < 100) begin
      if (!in_ready) busy++;
      @(negedge clk);
    end
    if (!in_ready) busy++;
    checks++;
    if (busy != 5 || result !== 32'h10) begin
      errors++;
      $display("FAIL sll4_busy: busy=%0d res=%h want 5 00000010", busy, result);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    int lat; logic [31:0] r; logic z, il;
    out_ready = 1'b0;
    run_op(4'd6, 32'hF0F0_1234, 32'h0FF0_4321, lat, r, z, il);
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = 4'd3; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== 32'hFF00_5115 || zero !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b ir=%b res=%h want 1 0 ff005115",
                 i, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_accept: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midshift();
    int seen = 0;
    out_ready = 1'b1;
    alu_ctrl = 4'd1; op_a = 32'h3; op_b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: ov=%b res=%h ir=%b want 0 0 1",
               out_valid, result, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    repeat (30) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: out_valid seen %0d times want 0", seen);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] r; logic z, il;
    logic [3:0] c; logic [31:0] a, b;
    logic [32:0] e; int el;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      e = ref_op(c, a, b); el = ref_lat(c, b);
      run_op(c, a, b, lat, r, z, il);
      checks++;
      if (lat !== el || r !== e[31:0] || z !== (e[31:0] == 0) || il !== e[32]) begin
        errors++;
        $display("FAIL rand_%0d ctrl=%h a=%h b=%h: lat=%0d res=%h z=%b il=%b want lat=%0d res=%h il=%b",
                 i, c, a, b, lat, r, z, il, el, e[31:0], e[32]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_wrap", 4'd3, 32'hFFFF_FFFF, 32'h1);
    test_directed("sub_neg", 4'd2, 32'd5, 32'd7);
    test_directed("sll_n4", 4'd1, 32'h1, 32'h24);
    test_directed("srl_n31", 4'd7, 32'h8000_0000, 32'd31);
    test_directed("sll_n0", 4'd1, 32'hDEAD_BEEF, 32'h40);
    test_directed("srl_n0", 4'd7, 32'h1234_5678, 32'h0);
    test_directed("or_op", 4'd9, 32'hA0A0_0000, 32'h0000_0505);
    test_directed("and_op", 4'd10, 32'hFF00_FF00, 32'h0F0F_0F0F);
    test_directed("illegal_5", 4'd5, 32'h1234, 32'h5678);
    test_directed("illegal_f", 4'd15, 32'h1, 32'h1);
    test_shift_busy();
    test_hold();
    test_reset_midshift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand and result width.
REQ-002 SHALL provide port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL provide port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port in_valid  input  1  request valid.
REQ-005 SHALL provide port in_ready  output  1  unit can accept a request.
REQ-006 SHALL provide port alu_ctrl  input  4  ALU control code from ALU_Control.
REQ-007 SHALL provide port op_a  input  XLEN  operand A (rs1).
REQ-008 SHALL provide port op_b  input  XLEN  operand B (rs2 or immediate).
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port result  output  XLEN  operation result.
REQ-012 SHALL provide port zero  output  1  result == 0.
REQ-013 SHALL provide port illegal  output  1  alu_ctrl was not a defined code.

Function
REQ-014 SHALL decode alu_ctrl: 0001 SLL, 0010 SUB, 0011 ADD, 0110 XOR, 0111 SRL, 1001 OR, 1010 AND; every other value, including X, is illegal.
REQ-015 SHALL implement states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on a rising edge where in_valid && in_ready, capturing alu_ctrl, op_a, op_b.
REQ-017 SHALL, for ADD/SUB/XOR/OR/AND, register the result at the accept edge and enter DONE: out_valid high in the cycle after acceptance (latency 1).
REQ-018 SHALL compute ADD as (op_a + op_b) mod 2^XLEN and SUB as (op_a - op_b) mod 2^XLEN, with no carry/overflow output.
REQ-019 SHALL use shift amount n = op_b[4:0] (low log2(XLEN) bits); upper op_b bits are ignored.
REQ-020 SHALL, for SLL/SRL with n = 0, enter DONE with result = op_a (latency 1).
REQ-021 SHALL, for SLL/SRL with n > 0, load the accumulator with op_a and a counter with n at the accept edge, then enter SHIFT.
REQ-022 SHALL, in SHIFT, shift the accumulator one bit per clock (SLL left, SRL right, zero fill) and decrement the counter; the edge that shifts with counter = 1 enters DONE (out_valid after n+1 edges including the accept edge).
REQ-023 SHALL, for an illegal code, enter DONE with result = 0 and illegal = 1 (latency 1).
REQ-024 SHALL hold result, zero and illegal stable in DONE until out_ready = 1; on that edge it enters IDLE and clears out_valid.
REQ-025 SHALL drive zero = (result == 0) and illegal as registered values, valid whenever out_valid = 1.
REQ-026 SHALL ignore in_valid and input changes outside IDLE; there is no back-to-back accept in the DONE-to-IDLE transition cycle.
REQ-027 SHALL make in_ready and out_valid depend only on state, with no combinational path from in_valid or out_ready.

Reset
REQ-028 SHALL, while reset_n = 0, force state IDLE, result = 0, zero = 0, illegal = 0, out_valid = 0, counter = 0, accumulator = 0, regardless of clk.
REQ-029 SHALL abandon any in-flight operation (SHIFT or DONE) when reset is asserted; no result for it is ever presented.
REQ-030 SHALL report in_ready = 1 in the first cycle after reset_n deasserts.

Verification
REQ-031 SHALL pass: ADD, op_a = 0xFFFFFFFF, op_b = 0x00000001, out_ready = 1 -> after 1 cycle out_valid = 1, result = 0x00000000, zero = 1; then IDLE.
REQ-032 SHALL pass: SUB, op_a = 5, op_b = 7 -> result = 0xFFFFFFFE, zero = 0, latency 1.
REQ-033 SHALL pass: SLL, op_a = 0x00000001, op_b = 0x00000024 (n = 4) -> in_ready low for 5 cycles, out_valid at edge 5, result = 0x00000010; SRL, op_a = 0x80000000, n = 31 -> result = 0x00000001 at edge 32.
REQ-034 SHALL pass: XOR, out_ready held 0 for 3 cycles -> result and out_valid stable, in_ready = 0, new in_valid ignored; out_ready = 1 -> IDLE next edge.
REQ-035 SHALL pass: alu_ctrl = 0101 -> out_valid after 1 cycle, illegal = 1, result = 0, zero = 1.
REQ-036 SHALL pass: SLL n = 20, reset_n pulsed low at cycle 6 -> out_valid = 0, result = 0 immediately, in_ready = 1 after release, no stale result emitted.
